osc_reset_sequencer: RTL and testbench
======================================

Name: osc_reset_sequencer

Overview:
- Sequences reset release for the MSS subsystem once the on-chip RC oscillator and fabric CCC are stable.
- Runs from the fabric oscillator clock (RCOSC 50 MHz via CLKINT). Waits for CCC lock, enforces a stabilization interval, then releases MSS reset and, after MSS_READY, fabric reset.
- Monitors lock during operation and re-sequences on sustained lock loss.
- Also provides a 1 us tick for fabric timers.

Parameters:
- CLK_FREQ_MHZ, 50, CLK_BASE frequency in MHz; TICK_1US period in cycles.
- STABLE_CYCLES, 1024, cycles lock must stay high before MSS release.
- RELEASE_GAP, 16, cycles between synchronized MSS_READY and fabric release.
- LOSS_FILTER, 4, consecutive lock-low cycles in RUN treated as lock loss.
- TIMEOUT_CYCLES, 65536, MSS_READY wait limit (optional feature only).

Ports:
- CLK_BASE in 1: fabric oscillator clock.
- RESET_N in 1: synchronous active-low reset.
- FAB_CCC_LOCK in 1: CCC lock, asynchronous.
- MSS_READY in 1: MSS ready indication, asynchronous.
- MSS_RESET_N out 1: active-low MSS reset.
- FAB_RESET_N out 1: active-low fabric reset.
- INIT_DONE out 1: high while sequence complete (RUN).
- TICK_1US out 1: one-cycle pulse every CLK_FREQ_MHZ cycles.
- LOSS_COUNT out 8: saturating count of lock-loss events.
- SEQ_STATE out 3: current state encoding.
- SEQ_FAIL out 1: MSS_READY timeout flag.

Behaviour:
- Reset and clocking:
  - One clock. Reset is synchronous and active-low: RESET_N sampled low on a CLK_BASE edge forces state WAIT_LOCK, clears all counters and synchronizers, LOSS_COUNT=0.
  - All outputs 0 during reset. Reset mid-sequence aborts immediately.
- Synchronizers:
  - FAB_CCC_LOCK and MSS_READY each pass through a 2-flop synchronizer (lock_s, ready_s).
  - Input sampled high at edge k is visible as lock_s at edge k+1.
- Outputs:
  - All outputs are registered, decoded from next state, so they change on the transition edge.
- State encoding: WAIT_LOCK=0, STABILIZE=1, RELEASE_MSS=2, GAP=3, RUN=4, LOCK_LOST=5, FAIL=6.
- WAIT_LOCK:
  - MSS_RESET_N=0, FAB_RESET_N=0, INIT_DONE=0.
  - lock_s=1 -> STABILIZE, counter=0.
- STABILIZE:
  - Counter increments each cycle. lock_s=0 on any cycle -> WAIT_LOCK, counter cleared.
  - Counter==STABLE_CYCLES-1 with lock_s=1 -> RELEASE_MSS; MSS_RESET_N=1 at that edge.
  - With FAB_CCC_LOCK first sampled high at edge k, MSS_RESET_N rises at edge k+2+STABLE_CYCLES.
- RELEASE_MSS:
  - MSS_RESET_N=1. ready_s=1 -> GAP, counter=0.
  - lock_s=0 -> LOCK_LOST.
- GAP:
  - Counts RELEASE_GAP cycles, then -> RUN; FAB_RESET_N=1 and INIT_DONE=1 at that edge.
  - MSS_READY first sampled high at edge m gives RUN at edge m+2+RELEASE_GAP.
  - lock_s=0 -> LOCK_LOST.
- RUN:
  - All releases held.
  - Lock-low run counter increments per consecutive lock_s=0 cycle and clears on lock_s=1.
  - Reaching LOSS_FILTER -> LOCK_LOST. Shorter glitches are ignored.
  - ready_s falling in RUN is ignored.
- LOCK_LOST:
  - On entry, FAB_RESET_N=0 and INIT_DONE=0; LOSS_COUNT increments, saturating at 255.
  - Next edge -> WAIT_LOCK, MSS_RESET_N=0. Fabric is always reset one cycle before MSS.
- TICK_1US:
  - Free-running counter 0..CLK_FREQ_MHZ-1, active whenever RESET_N=1, in every state.
  - Pulse on the cycle the counter wraps to 0.
  - First pulse CLK_FREQ_MHZ cycles after reset release.
- Widths:
  - Sequence counter is sized to max(STABLE_CYCLES, RELEASE_GAP, TIMEOUT_CYCLES).
  - Tick counter is sized to CLK_FREQ_MHZ.

Optional Feature:
- Macro OSC_RESET_SEQUENCER_TIMEOUT_EN.
- Defined:
  - In RELEASE_MSS, cycles without ready_s are counted.
  - Count reaching TIMEOUT_CYCLES -> FAIL: all resets 0, INIT_DONE=0, SEQ_FAIL=1.
  - FAIL exits only via RESET_N. Lock loss is not monitored in FAIL.
- Undefined:
  - RELEASE_MSS waits indefinitely.
  - SEQ_FAIL is tied 0; state 6 is unreachable.

Test Plan (STABLE_CYCLES=16, RELEASE_GAP=4, LOSS_FILTER=4, CLK_FREQ_MHZ=50, TIMEOUT_CYCLES=64):
- Nominal bring-up: reset low 5 cycles, FAB_CCC_LOCK high from edge 10, MSS_READY high from edge 40 -> MSS_RESET_N rises at edge 28, FAB_RESET_N/INIT_DONE at edge 46, SEQ_STATE=4.
- Unstable lock: lock high for 10 cycles, low 1, then high -> stays WAIT_LOCK/STABILIZE; MSS_RESET_N rises 18 edges after the final lock rise.
- Lock glitches in RUN: lock low 3 cycles -> no change, LOSS_COUNT=0. Lock low 4 cycles -> FAB_RESET_N=0 at 4th low-sample edge, MSS_RESET_N=0 one edge later, LOSS_COUNT=1, re-sequence completes once lock returns.
- Mid-sequence reset: assert RESET_N=0 during GAP -> next edge all outputs 0, SEQ_STATE=0. After release, full sequence repeats.
- Tick: after reset release, TICK_1US pulses at cycles 50, 100, 150, each exactly one cycle wide, independent of state.
- With OSC_RESET_SEQUENCER_TIMEOUT_EN: MSS_READY held low -> SEQ_FAIL=1 64 cycles after entering RELEASE_MSS, MSS_RESET_N=0. Only RESET_N clears it. Without the macro, SEQ_FAIL stays 0 indefinitely.

Source files
------------

// File: rtl/osc_reset_sequencer.sv
// -----------------------------------------------------------------------------
// osc_reset_sequencer
//
// Purpose:
//   Sequences reset release for the MSS subsystem once the RC oscillator and
//   the fabric CCC are stable. It waits for CCC lock and holds off for a
//   stabilization interval. It then releases MSS reset, waits for MSS_READY
//   plus a guard gap, and finally releases fabric reset. Lock is monitored
//   while running, and a sustained loss of lock re-sequences the whole chain.
//   A free-running 1 us tick for fabric timers is generated alongside.
//
// Ports:
//   CLK_BASE      in   1  fabric oscillator clock (RCOSC 50 MHz via CLKINT)
//   RESET_N       in   1  synchronous active-low reset
//   FAB_CCC_LOCK  in   1  CCC lock, asynchronous (2-flop synchronized)
//   MSS_READY     in   1  MSS ready indication, asynchronous (2-flop synchronized)
//   MSS_RESET_N   out  1  active-low MSS reset
//   FAB_RESET_N   out  1  active-low fabric reset
//   INIT_DONE     out  1  high while the sequence is complete (RUN)
//   TICK_1US      out  1  one-cycle pulse every CLK_FREQ_MHZ cycles
//   LOSS_COUNT    out  8  saturating count of lock-loss events
//   SEQ_STATE     out  3  current state encoding
//   SEQ_FAIL      out  1  MSS_READY timeout flag
//
// Build option:
//   OSC_RESET_SEQUENCER_TIMEOUT_EN - when defined, RELEASE_MSS gives up after
//   TIMEOUT_CYCLES cycles without MSS_READY and parks in FAIL until RESET_N.
//   When undefined, RELEASE_MSS waits indefinitely and SEQ_FAIL is tied 0.
// -----------------------------------------------------------------------------
module osc_reset_sequencer #(
    parameter int CLK_FREQ_MHZ   = 50,
    parameter int STABLE_CYCLES  = 1024,
    parameter int RELEASE_GAP    = 16,
    parameter int LOSS_FILTER    = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       CLK_BASE,
    input  logic       RESET_N,
    input  logic       FAB_CCC_LOCK,
    input  logic       MSS_READY,
    output logic       MSS_RESET_N,
    output logic       FAB_RESET_N,
    output logic       INIT_DONE,
    output logic       TICK_1US,
    output logic [7:0] LOSS_COUNT,
    output logic [2:0] SEQ_STATE,
    output logic       SEQ_FAIL
);

    // -------------------------------------------------------------------------
    // Counter sizing
    // -------------------------------------------------------------------------
    // One sequence counter serves every timed state: the stabilization
    // interval, the release gap, the MSS_READY timeout and the lock-low
    // filter in RUN. It must hold the largest of those limits.
    localparam int SEQ_MAX_A = (STABLE_CYCLES > RELEASE_GAP)    ? STABLE_CYCLES : RELEASE_GAP;
    localparam int SEQ_MAX_B = (SEQ_MAX_A     > TIMEOUT_CYCLES) ? SEQ_MAX_A     : TIMEOUT_CYCLES;
    localparam int SEQ_MAX   = (SEQ_MAX_B     > LOSS_FILTER)    ? SEQ_MAX_B     : LOSS_FILTER;
    localparam int CNT_W     = $clog2(SEQ_MAX + 1);
    localparam int TICK_W    = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;

    // Terminal counts: each timed state leaves on the last cycle of its window.
    localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(RELEASE_GAP - 1);
    localparam logic [CNT_W-1:0]  LOSS_LAST   = CNT_W'(LOSS_FILTER - 1);
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(CLK_FREQ_MHZ - 1);
`ifdef OSC_RESET_SEQUENCER_TIMEOUT_EN
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_STABILIZE   = 3'd1,
        ST_RELEASE_MSS = 3'd2,
        ST_GAP         = 3'd3,
        ST_RUN         = 3'd4,
        ST_LOCK_LOST   = 3'd5,
        ST_FAIL        = 3'd6
    } state_e;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic              lock_meta_q;
    logic              lock_s_q;
    logic              ready_meta_q;
    logic              ready_s_q;

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [TICK_W-1:0] tick_cnt_q,  tick_cnt_d;
    logic              tick_q,      tick_d;
    logic              mss_rst_n_q, mss_rst_n_d;
    logic              fab_rst_n_q, fab_rst_n_d;
    logic              init_done_q, init_done_d;
    logic [7:0]        loss_cnt_q,  loss_cnt_d;
`ifdef OSC_RESET_SEQUENCER_TIMEOUT_EN
    logic              seq_fail_q,  seq_fail_d;
`endif

    // -------------------------------------------------------------------------
    // 1 us tick: free-running in every state, only held by RESET_N.
    // The counter runs 0..CLK_FREQ_MHZ-1 and the pulse is registered on the
    // edge where it wraps, so the first pulse lands CLK_FREQ_MHZ edges after
    // reset release.
    // -------------------------------------------------------------------------
    always_comb begin
        tick_d     = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_d ? '0 : tick_cnt_q + 1'b1;
    end

    // -------------------------------------------------------------------------
    // Sequencer next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default before the case
    // statement; a path that skips an assignment would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s_q) begin
                    state_d = ST_STABILIZE;
                end
            end

            // Lock must be seen high on every one of STABLE_CYCLES cycles;
            // a single low sample restarts the whole wait.
            ST_STABILIZE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RELEASE_MSS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Lock loss takes priority over MSS_READY arriving on the same cycle.
            ST_RELEASE_MSS: begin
                if (!lock_s_q) begin
                    state_d = ST_LOCK_LOST;
                    cnt_d   = '0;
                end else if (ready_s_q) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
`ifdef OSC_RESET_SEQUENCER_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_FAIL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            ST_GAP: begin
                if (!lock_s_q) begin
                    state_d = ST_LOCK_LOST;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // In RUN the counter measures the current run of consecutive
            // lock-low cycles; any high sample forgives a shorter glitch.
            // ready_s is deliberately not looked at here.
            ST_RUN: begin
                if (lock_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == LOSS_LAST) begin
                    state_d = ST_LOCK_LOST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // One-cycle stop so fabric reset always asserts one edge before MSS.
            ST_LOCK_LOST: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end

            // Terminal until RESET_N; lock is not monitored here.
            ST_FAIL: begin
                state_d = ST_FAIL;
            end

            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state, so every output changes on the very
    // edge that performs the transition.
    // -------------------------------------------------------------------------
    always_comb begin
        mss_rst_n_d = (state_d == ST_RELEASE_MSS) || (state_d == ST_GAP) ||
                      (state_d == ST_RUN)         || (state_d == ST_LOCK_LOST);
        fab_rst_n_d = (state_d == ST_RUN);
        init_done_d = (state_d == ST_RUN);

        // LOCK_LOST only ever lasts one cycle, but the entry test keeps the
        // count honest should that change.
        loss_cnt_d = loss_cnt_q;
        if ((state_d == ST_LOCK_LOST) && (state_q != ST_LOCK_LOST) &&
            (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

`ifdef OSC_RESET_SEQUENCER_TIMEOUT_EN
    always_comb begin
        seq_fail_d = (state_d == ST_FAIL);
    end
`endif

    // -------------------------------------------------------------------------
    // State and output registers, synchronous active-low reset
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so that
    // the synchronizer chain shifts by one stage per edge regardless of
    // statement order; blocking assignments here would collapse it.
    always_ff @(posedge CLK_BASE) begin
        if (!RESET_N) begin
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            ready_meta_q <= 1'b0;
            ready_s_q    <= 1'b0;
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            tick_cnt_q   <= '0;
            tick_q       <= 1'b0;
            mss_rst_n_q  <= 1'b0;
            fab_rst_n_q  <= 1'b0;
            init_done_q  <= 1'b0;
            loss_cnt_q   <= 8'd0;
        end else begin
            lock_meta_q  <= FAB_CCC_LOCK;
            lock_s_q     <= lock_meta_q;
            ready_meta_q <= MSS_READY;
            ready_s_q    <= ready_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            tick_q       <= tick_d;
            mss_rst_n_q  <= mss_rst_n_d;
            fab_rst_n_q  <= fab_rst_n_d;
            init_done_q  <= init_done_d;
            loss_cnt_q   <= loss_cnt_d;
        end
    end

`ifdef OSC_RESET_SEQUENCER_TIMEOUT_EN
    always_ff @(posedge CLK_BASE) begin
        if (!RESET_N) begin
            seq_fail_q <= 1'b0;
        end else begin
            seq_fail_q <= seq_fail_d;
        end
    end
    assign SEQ_FAIL = seq_fail_q;
`else
    assign SEQ_FAIL = 1'b0;
`endif

    assign MSS_RESET_N = mss_rst_n_q;
    assign FAB_RESET_N = fab_rst_n_q;
    assign INIT_DONE   = init_done_q;
    assign TICK_1US    = tick_q;
    assign LOSS_COUNT  = loss_cnt_q;
    assign SEQ_STATE   = state_q;

endmodule

// File: tb/tb_osc_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_osc_reset_sequencer
//
// Self-checking bench for osc_reset_sequencer with the reduced test-plan
// parameters. A behavioural model tracks the sequence by time stamps
// (edge number at which each phase was entered) and a two-deep sample
// history per asynchronous input. Every output is compared on every edge,
// and directed scenarios add absolute-timing checks on top.
// -----------------------------------------------------------------------------
module tb_osc_reset_sequencer;

    localparam int F = 50;   // CLK_FREQ_MHZ
    localparam int S = 16;   // STABLE_CYCLES
    localparam int G = 4;    // RELEASE_GAP
    localparam int L = 4;    // LOSS_FILTER
    localparam int T = 64;   // TIMEOUT_CYCLES

`ifdef OSC_RESET_SEQUENCER_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    // Phase numbers as published on SEQ_STATE.
    localparam int P_WAIT = 0, P_STAB = 1, P_REL = 2, P_GAP = 3,
                   P_RUN  = 4, P_LOST = 5, P_FAIL = 6;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       lock   = 1'b0;
    logic       ready  = 1'b0;
    logic       mss_reset_n, fab_reset_n, init_done, tick_1us, seq_fail;
    logic [7:0] loss_count;
    logic [2:0] seq_state;

    always #5 clk = ~clk;

    osc_reset_sequencer #(
        .CLK_FREQ_MHZ  (F),
        .STABLE_CYCLES (S),
        .RELEASE_GAP   (G),
        .LOSS_FILTER   (L),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK_BASE    (clk),
        .RESET_N     (rst_n),
        .FAB_CCC_LOCK(lock),
        .MSS_READY   (ready),
        .MSS_RESET_N (mss_reset_n),
        .FAB_RESET_N (fab_reset_n),
        .INIT_DONE   (init_done),
        .TICK_1US    (tick_1us),
        .LOSS_COUNT  (loss_count),
        .SEQ_STATE   (seq_state),
        .SEQ_FAIL    (seq_fail)
    );

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, actual, expected, edge_no);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural reference model
    // ---------------------------------------------------------------------
    bit       m_valid = 1'b0;
    int       m_phase, m_mark, m_n, m_streak, m_loss;
    bit [1:0] m_lock_hist, m_ready_hist;  // [0] newest sample, [1] visible one
    bit       m_tick;

    task automatic model_enter_lost();
        m_phase = P_LOST;
        if (m_loss < 255) m_loss++;
    endtask

    task automatic model_edge();
        bit lk, rd;
        if (!rst_n) begin
            m_valid      = 1'b1;
            m_phase      = P_WAIT;
            m_mark       = 0;
            m_n          = 0;
            m_streak     = 0;
            m_loss       = 0;
            m_lock_hist  = '0;
            m_ready_hist = '0;
            m_tick       = 1'b0;
        end else begin
            lk = m_lock_hist[1];
            rd = m_ready_hist[1];
            m_n++;
            m_tick = (m_n % F == 0);
            case (m_phase)
                P_WAIT: if (lk) begin m_phase = P_STAB; m_mark = m_n; end
                P_STAB: begin
                    if (!lk) m_phase = P_WAIT;
                    else if (m_n - m_mark == S) begin m_phase = P_REL; m_mark = m_n; end
                end
                P_REL: begin
                    if (!lk) model_enter_lost();
                    else if (rd) begin m_phase = P_GAP; m_mark = m_n; end
                    else if (TIMEOUT_EN && (m_n - m_mark == T)) m_phase = P_FAIL;
                end
                P_GAP: begin
                    if (!lk) model_enter_lost();
                    else if (m_n - m_mark == G) begin m_phase = P_RUN; m_streak = 0; end
                end
                P_RUN: begin
                    m_streak = lk ? 0 : m_streak + 1;
                    if (m_streak == L) model_enter_lost();
                end
                P_LOST: m_phase = P_WAIT;
                default: m_phase = P_FAIL;
            endcase
            m_lock_hist  = {m_lock_hist[0], lock};
            m_ready_hist = {m_ready_hist[0], ready};
        end
    endtask

    // ---------------------------------------------------------------------
    // Edge stepping with per-edge comparison and transition logging
    // ---------------------------------------------------------------------
    logic prev_mss = 1'b0, prev_fab = 1'b0, prev_fail = 1'b0;
    int   mss_rise_edge = 0, mss_fall_edge = 0, fab_rise_edge = 0, fab_fall_edge = 0;
    int   fail_rise_edge = 0;
    int   tick_edges[$];

    task automatic step();
        bit exp_mss, exp_run;
        @(posedge clk);
        edge_no++;
        model_edge();
        #1;
        if (m_valid) begin
            exp_mss = (m_phase == P_REL) || (m_phase == P_GAP) ||
                      (m_phase == P_RUN) || (m_phase == P_LOST);
            exp_run = (m_phase == P_RUN);
            check("seq_state",   seq_state,   m_phase);
            check("mss_reset_n", mss_reset_n, exp_mss);
            check("fab_reset_n", fab_reset_n, exp_run);
            check("init_done",   init_done,   exp_run);
            check("tick_1us",    tick_1us,    m_tick);
            check("loss_count",  loss_count,  m_loss);
            check("seq_fail",    seq_fail,    m_phase == P_FAIL);
        end
        if (mss_reset_n === 1'b1 && !prev_mss) mss_rise_edge = edge_no;
        if (mss_reset_n === 1'b0 &&  prev_mss) mss_fall_edge = edge_no;
        if (fab_reset_n === 1'b1 && !prev_fab) fab_rise_edge = edge_no;
        if (fab_reset_n === 1'b0 &&  prev_fab) fab_fall_edge = edge_no;
        if (seq_fail    === 1'b1 && !prev_fail) fail_rise_edge = edge_no;
        if (tick_1us === 1'b1) tick_edges.push_back(edge_no);
        prev_mss  = (mss_reset_n === 1'b1);
        prev_fab  = (fab_reset_n === 1'b1);
        prev_fail = (seq_fail === 1'b1);
    endtask

    task automatic run_until_state(input int target, input int budget, input string tag);
        int k = 0;
        while (seq_state !== target[2:0] && k < budget) begin
            step();
            k++;
        end
        check(tag, seq_state, target);
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    initial begin
        int first_low, last_rise, rel_edge, len;

        // Reset held low for edges 1..5.
        repeat (5) step();
        check("reset_state",   seq_state, 0);
        check("reset_outputs", {mss_reset_n, fab_reset_n, init_done, tick_1us, seq_fail}, 0);
        check("reset_loss",    loss_count, 0);

        // Nominal bring-up: lock sampled high from edge 10, ready from edge 40.
        rst_n = 1'b1;
        repeat (4) step();
        lock = 1'b1;
        repeat (30) step();
        ready = 1'b1;
        repeat (10) step();
        check("nominal_mss_rise", mss_rise_edge, 28);
        check("nominal_fab_rise", fab_rise_edge, 46);
        check("nominal_state",    seq_state, P_RUN);
        check("nominal_init",     init_done, 1);

        // Three-cycle lock glitch in RUN is filtered.
        lock = 1'b0;
        repeat (3) step();
        lock = 1'b1;
        repeat (10) step();
        check("glitch3_loss",  loss_count, 0);
        check("glitch3_state", seq_state, P_RUN);

        // Four-cycle loss: fabric drops first, MSS one edge later.
        lock = 1'b0;
        repeat (4) step();
        first_low = edge_no - 3;
        lock = 1'b1;
        repeat (3) step();
        check("loss4_fab_fall",  fab_fall_edge, first_low + 5);
        check("loss4_mss_order", mss_fall_edge, fab_fall_edge + 1);
        check("loss4_count",     loss_count, 1);
        run_until_state(P_RUN, 60, "loss4_resequence");

        // Unstable lock: 10 high, 1 low, then steady high.
        rst_n = 1'b0; lock = 1'b0; ready = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        mss_rise_edge = 0;
        lock = 1'b1;
        repeat (10) step();
        lock = 1'b0;
        step();
        lock = 1'b1;
        last_rise = edge_no + 1;
        repeat (25) step();
        check("unstable_mss_rise", mss_rise_edge, last_rise + 18);
        check("unstable_state",    seq_state, P_REL);

`ifdef OSC_RESET_SEQUENCER_TIMEOUT_EN
        // MSS_READY never arrives: FAIL after T cycles in RELEASE_MSS.
        rel_edge = mss_rise_edge;
        run_until_state(P_FAIL, T + 20, "timeout_reach_fail");
        check("timeout_fail_edge", fail_rise_edge, rel_edge + T);
        check("timeout_mss",       mss_reset_n, 0);
        ready = 1'b1;
        lock  = 1'b0;
        repeat (10) step();
        check("timeout_sticky", seq_fail, 1);
        lock = 1'b1;
        rst_n = 1'b0;
        step();
        check("timeout_cleared", seq_fail, 0);
        rst_n = 1'b1;
`else
        // Without the timeout option RELEASE_MSS waits indefinitely.
        repeat (200) step();
        check("no_timeout_state", seq_state, P_REL);
        check("no_timeout_fail",  seq_fail, 0);
        ready = 1'b1;
`endif

        // Reset during GAP aborts at once; the sequence then repeats.
        run_until_state(P_GAP, 80, "reach_gap");
        rst_n = 1'b0;
        step();
        check("midreset_state",   seq_state, 0);
        check("midreset_outputs", {mss_reset_n, fab_reset_n, init_done, tick_1us, seq_fail}, 0);
        rst_n = 1'b1;
        tick_edges.delete();
        rel_edge = edge_no + 1;
        repeat (155) step();
        check("midreset_rerun", seq_state, P_RUN);
        check("tick_count", tick_edges.size(), 3);
        if (tick_edges.size() == 3) begin
            check("tick_first",  tick_edges[0] - rel_edge + 1, 50);
            check("tick_second", tick_edges[1] - rel_edge + 1, 100);
            check("tick_third",  tick_edges[2] - rel_edge + 1, 150);
        end

        // Randomized segments of lock / ready levels with occasional resets.
        for (int seg = 0; seg < 120; seg++) begin
            if ($urandom_range(0, 24) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) step();
                rst_n = 1'b1;
            end
            lock  = ($urandom_range(0, 3) != 0);
            ready = ($urandom_range(0, 2) != 0);
            len   = lock ? $urandom_range(1, 40) : $urandom_range(1, 6);
            repeat (len) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
